// File: rtl/reg16_shift_ctrl_if.sv
// Client-side bundle of reg16_shift_ctrl: request, per-client load data and
// shift lengths in, grant / done / result / busy back out.
interface reg16_shift_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic [1:0]       Req;
  logic [WIDTH-1:0] Data_A;
  logic [WIDTH-1:0] Data_B;
  logic [CNT_W-1:0] Len_A;
  logic [CNT_W-1:0] Len_B;
  logic [1:0]       Gnt;
  logic [1:0]       Done;
  logic [WIDTH-1:0] Result;
  logic             Busy;

  // Handshake: a client holds Req[i] (with its Data/Len stable) until the
  // controller accepts it in IDLE; Gnt[i] then marks ownership and a one-cycle
  // Done[i] qualifies Result. Req still high in the Done cycle is a new request.
  modport master (
    output Req, Data_A, Data_B, Len_A, Len_B,
    input  Gnt, Done, Result, Busy
  );

  modport slave (
    input  Req, Data_A, Data_B, Len_A, Len_B,
    output Gnt, Done, Result, Busy
  );
endinterface

// File: rtl/reg16_shift_ctrl.sv
// Two-client sequencer for a shared load/shift register: LOAD, Len shifts, CAPT.
// Optional macro REG16_CTRL_RR_EN selects round-robin instead of fixed A-first priority.
module reg16_shift_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  reg16_shift_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]  Reg_Q,
  output logic              Reg_Load,
  output logic              Reg_Shift_En,
  output logic [WIDTH-1:0]  Reg_D,
  output logic [1:0]        Dbg_State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_done;

  logic             w_accept;
  logic             w_pick_b;
  logic             w_load;
  logic             w_shift;
  logic             w_capt;
  logic [WIDTH-1:0] w_data_sel;
  logic [CNT_W-1:0] w_len_sel;
  logic [CNT_W-1:0] w_len_clamp;
  logic [1:0]       w_owner_oh;

`ifdef REG16_CTRL_RR_EN
  // r_rr_ptr = 0 prefers A, 1 prefers B; only consulted when both request.
  logic r_rr_ptr;

  always_comb begin
    w_pick_b = bus.Req[1];
    if (bus.Req == 2'b11) begin
      w_pick_b = r_rr_ptr;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_pick_b;
    end
  end
`else
  assign w_pick_b = bus.Req[1] & ~bus.Req[0];
`endif

  assign w_data_sel  = w_pick_b ? bus.Data_B : bus.Data_A;
  assign w_len_sel   = w_pick_b ? bus.Len_B  : bus.Len_A;
  assign w_len_clamp = (w_len_sel > LEN_MAX) ? LEN_MAX : w_len_sel;
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_capt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.Req) begin
          w_accept = 1'b1;
          w_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load = 1'b1;
        w_next = (r_len == '0) ? ST_CAPT : ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next = ST_CAPT;
        end
      end
      ST_CAPT: begin
        w_capt = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_owner <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
    end else if (w_accept) begin
      r_owner <= w_pick_b;
      r_data  <= w_data_sel;
      r_len   <= w_len_clamp;
    end
  end

  // Counter holds the remaining shifts including the current one.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= r_len;
    end else if (w_shift) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_result <= '0;
      r_done   <= 2'b00;
    end else begin
      r_done <= w_capt ? w_owner_oh : 2'b00;
      if (w_capt) begin
        r_result <= Reg_Q;
      end
    end
  end

  assign Reg_Load     = w_load;
  assign Reg_Shift_En = w_shift;
  assign Reg_D        = r_data;
  assign Dbg_State    = r_state;

  assign bus.Gnt    = (r_state != ST_IDLE) ? w_owner_oh : 2'b00;
  assign bus.Done   = r_done;
  assign bus.Result = r_result;
  assign bus.Busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg16_shift_ctrl.sv
// Directed bench for reg16_shift_ctrl with a rotate-left register model on Reg_Q.
module tb_reg16_shift_ctrl;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  reg16_shift_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic [WIDTH-1:0] Reg_Q;
  logic             Reg_Load;
  logic             Reg_Shift_En;
  logic [WIDTH-1:0] Reg_D;
  logic [1:0]       Dbg_State;

  reg16_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .bus          (bus),
    .Reg_Q        (Reg_Q),
    .Reg_Load     (Reg_Load),
    .Reg_Shift_En (Reg_Shift_En),
    .Reg_D        (Reg_D),
    .Dbg_State    (Dbg_State)
  );

  // Shared register model: load, or rotate left by one per shift.
  logic [WIDTH-1:0] model_q = '0;
  always @(posedge Clk) begin
    if (Reg_Load) model_q <= Reg_D;
    else if (Reg_Shift_En) model_q <= {model_q[WIDTH-2:0], model_q[WIDTH-1]};
  end
  assign Reg_Q = model_q;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [1:0]       exp_own_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.Req = 2'b00;
    Reset = 1'b0;
    #7;
    Reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0]       req;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [CNT_W-1:0] len_a;
    logic [CNT_W-1:0] len_b;
    logic [1:0]       exp_done;
    int               exp_shifts;
    logic [WIDTH-1:0] exp_result;
  } vec_t;

  vec_t vecs[7];

  task automatic run_xfer(input vec_t v, input int idx);
    int load_cyc, shifts, done_cyc, overlap;
    logic [1:0]       gnt_seen, done_val;
    logic [WIDTH-1:0] load_d, exp_d;
    string tag;
    tag = $sformatf("v%0d", idx);
    load_cyc = -1; shifts = 0; done_cyc = -1; overlap = 0;
    gnt_seen = '0; done_val = '0; load_d = '0;
    exp_d = (v.exp_done == 2'b01) ? v.data_a : v.data_b;
    @(posedge Clk); #1;
    check({tag, "_idle"}, Dbg_State, ST_IDLE);
    bus.Req = v.req; bus.Data_A = v.data_a; bus.Data_B = v.data_b;
    bus.Len_A = v.len_a; bus.Len_B = v.len_b;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin
        bus.Data_A = ~v.data_a; bus.Data_B = ~v.data_b;
        bus.Len_A = 5'd7; bus.Len_B = 5'd9;
      end
      if (Reg_Load) begin load_cyc = c; load_d = Reg_D; gnt_seen = bus.Gnt; end
      if (Reg_Shift_En) shifts++;
      if (Reg_Load && Reg_Shift_En) overlap++;
      if (bus.Done != 2'b00) begin
        done_cyc = c; done_val = bus.Done; bus.Req = 2'b00;
        check({tag, "_busy_done"}, bus.Busy, 1'b0);
        break;
      end
    end
    bus.Req = 2'b00;
    check({tag, "_load_cyc"}, load_cyc, 1);
    check({tag, "_reg_d"}, load_d, exp_d);
    check({tag, "_gnt"}, gnt_seen, v.exp_done);
    check({tag, "_shifts"}, shifts, v.exp_shifts);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_done_cyc"}, done_cyc, v.exp_shifts + 3);
    check({tag, "_done"}, done_val, v.exp_done);
    check({tag, "_result"}, bus.Result, v.exp_result);
    @(posedge Clk); #1;
    check({tag, "_done_pulse"}, bus.Done, 2'b00);
    check({tag, "_no_reaccept"}, bus.Busy, 1'b0);
  endtask

  initial begin
    int done_cnt, last_done, c0, d0, d1, bl;
    logic [1:0] got_own;
    bus.Req = 2'b00; bus.Data_A = '0; bus.Data_B = '0; bus.Len_A = '0; bus.Len_B = '0;

    vecs[0] = '{2'b01, 16'hA5A5, 16'h1357, 5'd4,  5'd2,  2'b01, 4,  16'h5A5A};
    vecs[1] = '{2'b10, 16'hFFFF, 16'h1234, 5'd3,  5'd0,  2'b10, 0,  16'h1234};
    vecs[2] = '{2'b01, 16'h8001, 16'h0000, 5'd31, 5'd1,  2'b01, 16, 16'h8001};
    vecs[3] = '{2'b10, 16'h0000, 16'h00F0, 5'd0,  5'd1,  2'b10, 1,  16'h01E0};
    vecs[4] = '{2'b01, 16'hC003, 16'h5555, 5'd16, 5'd5,  2'b01, 16, 16'hC003};
    vecs[5] = '{2'b01, 16'h0001, 16'hAAAA, 5'd17, 5'd3,  2'b01, 16, 16'h0001};
    vecs[6] = '{2'b10, 16'h7777, 16'h8000, 5'd2,  5'd3,  2'b10, 3,  16'h0004};

    // Reset state, checked while reset is still low.
    #1;
    check("rst_gnt", bus.Gnt, 2'b00);
    check("rst_done", bus.Done, 2'b00);
    check("rst_result", bus.Result, 16'h0000);
    check("rst_load", Reg_Load, 1'b0);
    check("rst_shift", Reg_Shift_En, 1'b0);
    check("rst_reg_d", Reg_D, 16'h0000);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_state", Dbg_State, ST_IDLE);
    #11 Reset = 1'b1;

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], i);

    // Asynchronous reset in the middle of SHIFT.
    @(posedge Clk); #1;
    bus.Req = 2'b01; bus.Data_A = 16'h0F0F; bus.Len_A = 5'd8;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (Reg_Shift_En) break;
    end
    bus.Req = 2'b00;
    check("mid_in_shift", Reg_Shift_En, 1'b1);
    check("mid_result_before", bus.Result, 16'h0004);
    #2 Reset = 1'b0;
    #1;
    check("mid_busy", bus.Busy, 1'b0);
    check("mid_gnt", bus.Gnt, 2'b00);
    check("mid_shift", Reg_Shift_En, 1'b0);
    check("mid_done", bus.Done, 2'b00);
    #2 Reset = 1'b1;
    @(posedge Clk); #1;
    check("mid_state_after", Dbg_State, ST_IDLE);
    check("mid_result_after", bus.Result, 16'h0000);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk); #1;
      if (bus.Done != 2'b00) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);

    // Both clients requesting continuously for four transfers.
    do_reset();
    @(posedge Clk); #1;
`ifdef REG16_CTRL_RR_EN
    exp_own_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_q = '{16'h4444, 16'h8888, 16'h4444, 16'h8888};
`else
    exp_own_q = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_q = '{16'h4444, 16'h4444, 16'h4444, 16'h4444};
`endif
    bus.Data_A = 16'h1111; bus.Data_B = 16'h2222; bus.Len_A = 5'd2; bus.Len_B = 5'd2;
    bus.Req = 2'b11;
    done_cnt = 0; last_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk); #1;
      if (bus.Done != 2'b00) begin
        done_cnt++;
        got_own = bus.Done;
        check($sformatf("rr%0d_spacing", done_cnt), c - last_done, 5);
        last_done = c;
        if (exp_own_q.size() > 0) begin
          check($sformatf("rr%0d_owner", done_cnt), got_own, exp_own_q.pop_front());
          check($sformatf("rr%0d_result", done_cnt), bus.Result, exp_q.pop_front());
        end
        if (done_cnt == 4) begin bus.Req = 2'b00; break; end
      end
    end
    bus.Req = 2'b00;
    check("rr_done_count", done_cnt, 4);

    // A drops Req during SHIFT while B is pending.
    do_reset();
    @(posedge Clk); #1;
    bus.Data_A = 16'h00FF; bus.Len_A = 5'd3; bus.Data_B = 16'hBEEF; bus.Len_B = 5'd0;
    bus.Req = 2'b11;
    d0 = -1; d1 = -1; bl = -1; c0 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge Clk); #1;
      if (Reg_Shift_En && c0 < 0) begin c0 = c; bus.Req = 2'b10; end
      if (Reg_Load && bus.Gnt == 2'b10) begin
        bl = c;
        check("drop_b_reg_d", Reg_D, 16'hBEEF);
      end
      if (bus.Done == 2'b01) begin
        d0 = c;
        check("drop_a_result", bus.Result, 16'h07F8);
      end
      if (bus.Done == 2'b10) begin
        d1 = c; bus.Req = 2'b00;
        check("drop_b_result", bus.Result, 16'hBEEF);
        break;
      end
    end
    bus.Req = 2'b00;
    check("drop_a_done_cyc", d0, 6);
    check("drop_b_load_cyc", bl, 7);
    check("drop_b_done_cyc", d1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
